// File: rtl/countdown_timer_pkg.sv
// Shared types and limits for the countdown timer.
// State encoding and per-digit maxima live here.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam int CS_MAX   = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int CS_W   = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/countdown_timer_down_counter.sv
// One digit of the countdown chain: wraps to MAX_VAL on borrow,
// clamps loaded values to MAX_VAL.
module down_counter #(
    parameter int BIT_WIDTH = 7,
    parameter int MAX_VAL   = 99
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 ld,
    input  logic [BIT_WIDTH-1:0] ld_val,
    input  logic                 i_borrow_req,
    output logic [BIT_WIDTH-1:0] o_time,
    output logic                 o_borrow
);

    localparam logic [BIT_WIDTH-1:0] MAXV = BIT_WIDTH'(MAX_VAL);

    // A decrement at zero wraps and asks the next digit up for a borrow.
    assign o_borrow = i_borrow_req && (o_time == '0);

    // Digit register: clear beats load beats decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_time <= '0;
        end else if (clr) begin
            o_time <= '0;
        end else if (ld) begin
            o_time <= (ld_val > MAXV) ? MAXV : ld_val;
        end else if (i_borrow_req) begin
            o_time <= (o_time == '0) ? MAXV : o_time - 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: run/pause/done FSM, 100 Hz prescaler and
// a cs/sec/min/hour borrow chain built from down_counter digits.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int FCOUNT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [4:0]  load_hour,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic        option,
    output logic [6:0]  low_digit,
    output logic [5:0]  high_digit,
    output logic        running,
    output logic        done
);

    localparam int PW = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(FCOUNT - 1);

    state_t state, state_nxt;
    logic [PW-1:0] presc;
    logic tick;
    logic do_load;
    logic nonzero;
    logic is_last;

    logic [CS_W-1:0]   cs;
    logic [SEC_W-1:0]  sec;
    logic [MIN_W-1:0]  min;
    logic [HOUR_W-1:0] hour;
    logic cs_bor, sec_bor, min_bor, hr_bor;

    assign tick    = (state == S_RUN) && (presc == P_LAST);
    assign do_load = load && !clear && (state == S_IDLE);
    assign nonzero = |{cs, sec, min, hour};
    assign is_last = (cs == CS_W'(1)) && !(|{sec, min, hour});

    down_counter #(.BIT_WIDTH(CS_W), .MAX_VAL(CS_MAX)) u_cs (
        .clk(clk), .rst(rst), .clr(clear), .ld(do_load),
        .ld_val('0), .i_borrow_req(tick),
        .o_time(cs), .o_borrow(cs_bor)
    );

    down_counter #(.BIT_WIDTH(SEC_W), .MAX_VAL(SEC_MAX)) u_sec (
        .clk(clk), .rst(rst), .clr(clear), .ld(do_load),
        .ld_val(load_sec), .i_borrow_req(cs_bor),
        .o_time(sec), .o_borrow(sec_bor)
    );

    down_counter #(.BIT_WIDTH(MIN_W), .MAX_VAL(MIN_MAX)) u_min (
        .clk(clk), .rst(rst), .clr(clear), .ld(do_load),
        .ld_val(load_min), .i_borrow_req(sec_bor),
        .o_time(min), .o_borrow(min_bor)
    );

    down_counter #(.BIT_WIDTH(HOUR_W), .MAX_VAL(HOUR_MAX)) u_hour (
        .clk(clk), .rst(rst), .clr(clear), .ld(do_load),
        .ld_val(load_hour), .i_borrow_req(min_bor),
        .o_time(hour), .o_borrow(hr_bor)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state; a tick reaching zero wins over a same-cycle pause,
    // and an hour borrow (chain underflow) is treated as expiry.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (!load && run_stop && nonzero) state_nxt = S_RUN;
                S_RUN: begin
                    if (tick && (is_last || hr_bor)) state_nxt = S_DONE;
                    else if (run_stop)               state_nxt = S_PAUSE;
                end
                S_PAUSE: if (run_stop) state_nxt = S_RUN;
                S_DONE:  if (run_stop) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Prescaler: counts in RUN, holds in PAUSE, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (state == S_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end else if (state != S_PAUSE) begin
            presc <= '0;
        end
    end

    assign low_digit  = option ? {1'b0, min}  : cs;
    assign high_digit = option ? {1'b0, hour} : sec;
    assign running    = (state == S_RUN);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer against a
// total-centiseconds reference model.
module tb_countdown_timer;

    localparam int FC = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run_stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic       option = 1'b0;
    logic [6:0] low_digit;
    logic [5:0] high_digit;
    logic       running;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    int m_st  = M_IDLE;
    int m_rem = 0;
    int m_pc  = 0;

    countdown_timer #(.FCOUNT(FC)) dut (
        .clk(clk), .rst(rst), .run_stop(run_stop), .clear(clear),
        .load(load), .load_hour(load_hour), .load_min(load_min),
        .load_sec(load_sec), .option(option),
        .low_digit(low_digit), .high_digit(high_digit),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_step(input bit c, input bit l, input bit r);
        bit tk;
        if (c) begin
            m_st = M_IDLE; m_rem = 0; m_pc = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    m_pc = 0;
                    if (l)
                        m_rem = lim(int'(load_hour), 23) * 360000
                              + lim(int'(load_min), 59) * 6000
                              + lim(int'(load_sec), 59) * 100;
                    else if (r && m_rem > 0)
                        m_st = M_RUN;
                end
                M_RUN: begin
                    tk = (m_pc == FC - 1);
                    m_pc = tk ? 0 : m_pc + 1;
                    if (tk) m_rem--;
                    if (tk && m_rem == 0) m_st = M_DONE;
                    else if (r)           m_st = M_PAUSE;
                end
                M_PAUSE: if (r) m_st = M_RUN;
                default: begin
                    m_pc = 0;
                    if (r) m_st = M_IDLE;
                end
            endcase
        end
    endtask

    task automatic check_outs();
        int el, eh;
        el = option ? (m_rem / 6000) % 60 : m_rem % 100;
        eh = option ? m_rem / 360000 : (m_rem / 100) % 60;
        chk("low_digit", 32'(low_digit), el);
        chk("high_digit", 32'(high_digit), eh);
        chk("running", 32'(running), 32'(m_st == M_RUN));
        chk("done", 32'(done), 32'(m_st == M_DONE));
    endtask

    task automatic cyc(input bit c, input bit l, input bit r);
        clear = c; load = l; run_stop = r;
        @(posedge clk);
        model_step(c, l, r);
        #1;
        check_outs();
        clear = 0; load = 0; run_stop = 0;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic set_load(input int h, input int m, input int s);
        load_hour = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    endtask

    initial begin
        int r;
        #2;
        chk("rst_low", 32'(low_digit), 0);
        chk("rst_high", 32'(high_digit), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk);
        rst = 0;

        // Load 0:00:02, run to expiry, acknowledge.
        set_load(0, 0, 2);
        cyc(0, 1, 0);
        chk("load2_high", 32'(high_digit), 2);
        cyc(0, 0, 1);
        chk("run2_running", 32'(running), 1);
        idle_n(805);
        chk("exp_done", 32'(done), 1);
        chk("exp_running", 32'(running), 0);
        cyc(0, 0, 1);

        // Load 1:00:00, first tick borrows across every digit.
        set_load(1, 0, 0);
        option = 1;
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle_n(4);
        chk("borrow_min", 32'(low_digit), 59);
        chk("borrow_hour", 32'(high_digit), 0);
        option = 0;
        #1;
        check_outs();
        cyc(1, 0, 0);

        // Pause after two prescaler counts, hold, resume.
        set_load(0, 0, 5);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle_n(2);
        cyc(0, 0, 1);
        idle_n(50);
        cyc(0, 0, 1);
        idle_n(10);
        cyc(1, 0, 0);

        // Clamp of out-of-range preset.
        set_load(31, 60, 63);
        cyc(0, 1, 0);
        chk("clamp_cs", 32'(low_digit), 0);
        chk("clamp_sec", 32'(high_digit), 59);
        option = 1;
        #1;
        chk("clamp_min", 32'(low_digit), 59);
        chk("clamp_hour", 32'(high_digit), 23);
        option = 0;
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        set_load(0, 0, 1);
        cyc(0, 1, 0);
        idle_n(3);
        cyc(1, 0, 0);

        // Zero value does not start; clear with run_stop mid-run.
        cyc(0, 0, 1);
        chk("zero_run", 32'(running), 0);
        set_load(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle_n(6);
        cyc(1, 0, 1);
        chk("clr_running", 32'(running), 0);

        // Async reset between edges mid-run.
        set_load(0, 0, 3);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle_n(6);
        #3;
        rst = 1;
        #1;
        m_st = M_IDLE; m_rem = 0; m_pc = 0;
        chk("arst_low", 32'(low_digit), 0);
        chk("arst_high", 32'(high_digit), 0);
        chk("arst_running", 32'(running), 0);
        @(negedge clk);
        rst = 0;
        idle_n(10);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) option = ~option;
            if ($urandom_range(0, 7) == 0)
                set_load(
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : 0,
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                                : $urandom_range(0, 2));
            r = $urandom_range(0, 999);
            cyc(r < 2, r >= 2 && r < 60, (r >= 50 && r < 80) || r >= 995);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL expose parameter FCOUNT, default 1_000_000, meaning the number of clk cycles per 100 Hz decrement tick.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run_stop  input  1  single-cycle debounced pulse that starts, pauses, resumes or acknowledges the timer.
REQ-005 clear  input  1  single-cycle pulse that zeroes the timer and returns the FSM to IDLE.
REQ-006 load  input  1  single-cycle pulse that captures load_hour, load_min and load_sec.
REQ-007 load_hour  input  5  preset hours, 0-23.
REQ-008 load_min  input  6  preset minutes, 0-59.
REQ-009 load_sec  input  6  preset seconds, 0-59.
REQ-010 option  input  1  display select: 0 selects cs/sec, 1 selects min/hour.
REQ-011 low_digit  output  7  cs (0-99) when option=0; zero-extended min when option=1.
REQ-012 high_digit  output  6  sec when option=0; zero-extended hour when option=1.
REQ-013 running  output  1  high while the FSM is in RUN.
REQ-014 done  output  1  high while the FSM is in DONE.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSE and DONE.
REQ-016 In IDLE, a load pulse SHALL write hour, min and sec on the next edge and set cs to 0, clamping values above 23/59/59 to 23/59/59.
REQ-017 In IDLE, run_stop SHALL go to RUN when the held value is nonzero; with an all-zero value it SHALL stay in IDLE.
REQ-018 In RUN, run_stop SHALL go to PAUSE; in PAUSE, run_stop SHALL go back to RUN.
REQ-019 In DONE, run_stop SHALL go to IDLE, and the value SHALL stay zero.
REQ-020 clear SHALL go to IDLE from any state, zeroing cs, sec, min, hour and the prescaler on the next edge.
REQ-021 load SHALL be ignored outside IDLE.
REQ-022 Same-cycle priority SHALL be clear > load > run_stop; load together with run_stop in IDLE performs the load only and stays in IDLE.
REQ-023 The prescaler SHALL count only in RUN, hold its value in PAUSE, and be zero in IDLE and DONE.
REQ-024 An internal tick SHALL pulse for one cycle when the prescaler equals FCOUNT-1 in RUN, and the prescaler SHALL wrap to 0 at that point.
REQ-025 Each tick SHALL decrement the BCD-free binary chain cs/sec/min/hour by one centisecond, with the new value visible on the cycle after the tick.
REQ-026 Borrow rules: cs 0->99 borrows from sec; sec 0->59 borrows from min; min 0->59 borrows from hour.
REQ-027 The chain SHALL never underflow below all-zero.
REQ-028 A tick that brings the value to all-zero SHALL move the FSM to DONE on the same edge, so done rises together with the zero value.
REQ-029 low_digit and high_digit SHALL be combinational muxes of the registered counters through option.
REQ-030 running and done SHALL be decoded directly from the registered state.

Reset
REQ-031 rst SHALL force state=IDLE, cs=sec=min=hour=0 and prescaler=0 immediately, independent of clk.
REQ-032 During reset, running=0, done=0, low_digit=0 and high_digit=0.
REQ-033 A reset asserted mid-RUN SHALL discard the count with no residual tick after release.

Structure
REQ-034 A shared package SHALL hold the state encoding and the constants CS_MAX=99, SEC_MAX=59, MIN_MAX=59 and HOUR_MAX=23.
REQ-035 One sub-module, down_counter, SHALL be provided with parameters BIT_WIDTH and MAX_VAL, and ports clk, rst, clr, ld, ld_val, i_borrow_req and o_time, o_borrow.
REQ-036 down_counter SHALL be instantiated four times.
REQ-037 The FSM and prescaler SHALL live in countdown_timer.

Verification (FCOUNT=4 in simulation)
REQ-038 load 0:00:02, then run_stop: running=1; the first tick gives sec=1, cs=99; after 200 ticks (800 cycles) done=1, value 0, running=0.
REQ-039 load 1:00:00, run, one tick: hour=0, min=59, sec=59, cs=99; with option=1, low_digit=59 and high_digit=0.
REQ-040 run, pause after 2 prescaler counts, hold 50 cycles: value and prescaler are unchanged; resume: the next tick arrives 2 cycles later.
REQ-041 load_hour=31, load_min=60, load_sec=63: loaded value reads 23:59:59:00.
REQ-042 run_stop with zero value: stays IDLE. Mid-RUN clear together with run_stop: IDLE, all zero.
REQ-043 rst asserted asynchronously mid-RUN between clk edges: outputs are 0 immediately, and no decrement occurs after release.
